// File: rtl/etc_pkg.sv
// Shared types and constants for the toll-station lane logic: FSM encoding,
// lane indices and the car-count width used by the counter and service blocks.
package etc_pkg;

    localparam int CNT_W = 2;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef logic [1:0] lane_t;
    localparam lane_t LANE1 = 2'd0;
    localparam lane_t LANE2 = 2'd1;
    localparam lane_t LANE3 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        OPEN = 2'b10,
        DONE = 2'b11
    } state_e;

    // Next lane in round-robin order, wrapping lane 3 back to lane 1.
    function automatic lane_t next_lane(lane_t l);
        case (l)
            LANE1:   return LANE2;
            LANE2:   return LANE3;
            default: return LANE1;
        endcase
    endfunction

    // Barrier bit for a lane index.
    function automatic logic [2:0] lane_onehot(lane_t l);
        return 3'b001 << l;
    endfunction

endpackage

// File: rtl/lane_gate_ctrl_if.sv
// Handshake between the lane service controller and the ETC tag reader.
// The controller raises tag_req with tag_lane; the reader answers with a
// tag_ack strobe qualified by tag_ok.
interface lane_gate_ctrl_if;
    import etc_pkg::*;

    logic  tag_req;
    lane_t tag_lane;
    logic  tag_ack;
    logic  tag_ok;

    modport master (
        output tag_req,
        output tag_lane,
        input  tag_ack,
        input  tag_ok
    );

    modport slave (
        input  tag_req,
        input  tag_lane,
        output tag_ack,
        output tag_ok
    );

endinterface

// File: rtl/rr_arb3.sv
// Three-request round-robin arbiter. The search begins at the lane after the
// last granted one, so simultaneous requesters are served in rotating order.
module rr_arb3
    import etc_pkg::*;
(
    input  logic [2:0] req,
    input  lane_t      last,
    output lane_t      grant,
    output logic       valid
);

    lane_t first;
    lane_t second;
    lane_t third;

    assign first  = next_lane(last);
    assign second = next_lane(first);
    assign third  = next_lane(second);

    // Pick the first requester in rotating priority order.
    always_comb begin
        grant = first;
        valid = 1'b1;
        if (req[first]) begin
            grant = first;
        end else if (req[second]) begin
            grant = second;
        end else if (req[third]) begin
            grant = third;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/lane_gate_ctrl.sv
// Service side of the three-lane car counter. Compares each lane's arrival
// count with its served count, picks a waiting lane round-robin, reads its
// ETC tag, opens the barrier for a fixed time on a paid tag, and retires the
// car. Invalid tags and reader timeouts raise a one-cycle alarm and still
// retire the car.
module lane_gate_ctrl
    import etc_pkg::*;
#(
    parameter int OPEN_CYCLES = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  cnt_t              car1,
    input  cnt_t              car2,
    input  cnt_t              car3,
    lane_gate_ctrl_if.master  tag_if,
    output logic [2:0]        gate_open,
    output logic              alarm,
    output cnt_t              served1,
    output cnt_t              served2,
    output cnt_t              served3,
    output logic              busy
);

    // One timer serves both the ack wait and the barrier hold time.
    localparam int TMR_MAX = (ACK_TIMEOUT > OPEN_CYCLES) ? ACK_TIMEOUT : OPEN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);

    state_e           state_q,    state_d;
    logic [TMR_W-1:0] timer_q,    timer_d;
    lane_t            tag_lane_q, tag_lane_d;
    lane_t            last_q,     last_d;
    cnt_t             served_q [3];
    cnt_t             served_d [3];
    logic             alarm_q,    alarm_d;

    cnt_t       pending [3];
    logic [2:0] lane_req;
    lane_t      arb_grant;
    logic       arb_valid;

    // Cars waiting per lane: arrivals minus services, modulo the count width.
    assign pending[LANE1] = car1 - served_q[LANE1];
    assign pending[LANE2] = car2 - served_q[LANE2];
    assign pending[LANE3] = car3 - served_q[LANE3];

    assign lane_req[LANE1] = (pending[LANE1] != '0);
    assign lane_req[LANE2] = (pending[LANE2] != '0);
    assign lane_req[LANE3] = (pending[LANE3] != '0);

    rr_arb3 u_arb (
        .req   (lane_req),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Next-state logic for the service FSM, timer, grant latch and served counts.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned (no latch); blocking assignments are correct here.
        state_d    = state_q;
        timer_d    = timer_q;
        tag_lane_d = tag_lane_q;
        last_d     = last_q;
        served_d   = served_q;
        alarm_d    = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (arb_valid) begin
                    tag_lane_d = arb_grant;
                    state_d    = REQ;
                end
            end

            REQ: begin
                // An ack on the final timeout cycle takes priority.
                if (tag_if.tag_ack) begin
                    timer_d = '0;
                    if (tag_if.tag_ok) begin
                        state_d = OPEN;
                    end else begin
                        alarm_d = 1'b1;
                        state_d = DONE;
                    end
                end else if (timer_q == ACK_LAST) begin
                    alarm_d = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            OPEN: begin
                if (timer_q == OPEN_LAST) begin
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            DONE: begin
                served_d[tag_lane_q] = served_q[tag_lane_q] + 1'b1;
                last_d               = tag_lane_q;
                state_d              = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops the transaction and closes the barriers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            tag_lane_q <= LANE1;
            last_q     <= LANE3;
            alarm_q    <= 1'b0;
            // NOTE: the served counts are a tiny register array, not RAM, and
            // must start at zero to match the arrival counters, so reset them.
            for (int i = 0; i < 3; i++) begin
                served_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tag_lane_q <= tag_lane_d;
            last_q     <= last_d;
            alarm_q    <= alarm_d;
            served_q   <= served_d;
        end
    end

    // Outputs decoded from registered state; gates are only open in OPEN.
    assign tag_if.tag_req  = (state_q == REQ);
    assign tag_if.tag_lane = tag_lane_q;
    assign gate_open       = (state_q == OPEN) ? lane_onehot(tag_lane_q) : 3'b000;
    assign alarm           = alarm_q;
    assign busy            = (state_q != IDLE);
    assign served1         = served_q[LANE1];
    assign served2         = served_q[LANE2];
    assign served3         = served_q[LANE3];

endmodule

// File: tb/tb_lane_gate_ctrl.sv
// Directed bench for lane_gate_ctrl: service order, ack/reject/timeout paths,
// barrier hold time, counter wrap and asynchronous reset mid-transaction.
module tb_lane_gate_ctrl;
    import etc_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    cnt_t       car1, car2, car3;
    logic [2:0] gate_open;
    logic       alarm;
    logic       busy;
    cnt_t       served1, served2, served3;

    int errors = 0;
    int checks = 0;

    lane_gate_ctrl_if tag_if ();

    lane_gate_ctrl #(
        .OPEN_CYCLES (8),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .car1      (car1),
        .car2      (car2),
        .car3      (car3),
        .tag_if    (tag_if),
        .gate_open (gate_open),
        .alarm     (alarm),
        .served1   (served1),
        .served2   (served2),
        .served3   (served3),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        car1           = '0;
        car2           = '0;
        car3           = '0;
        tag_if.tag_ack = 1'b0;
        tag_if.tag_ok  = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!tag_if.tag_req && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(tag_if.tag_req), 32'd1);
    endtask

    // One transaction: ack strobe at req-relative cycle ack_at (<0: never).
    // Counts req cycles, gate cycles on the expected lane and alarm pulses.
    task automatic run_txn(input string tag, input int lane, input int ack_at, input bit ok,
                           input int exp_req, input int exp_gate, input int exp_alarm);
        logic [2:0] exp_oh;
        int cyc     = 0;
        int req_n   = 0;
        int gate_n  = 0;
        int alarm_n = 0;
        int bad     = 0;
        exp_oh = 3'(1 << lane);
        wait_req(tag);
        check({tag, "_lane"}, 32'(tag_if.tag_lane), 32'(lane));
        while (busy && cyc < 60) begin
            if (tag_if.tag_req) req_n++;
            if (gate_open == exp_oh) gate_n++;
            else if (gate_open != 3'b000) bad++;
            if (alarm) alarm_n++;
            if (alarm && gate_open != 3'b000) bad++;
            tag_if.tag_ack = (cyc == ack_at);
            tag_if.tag_ok  = ok;
            tick();
            cyc++;
        end
        tag_if.tag_ack = 1'b0;
        check({tag, "_done"},  32'(busy), 32'd0);
        check({tag, "_reqn"},  32'(req_n), 32'(exp_req));
        check({tag, "_gaten"}, 32'(gate_n), 32'(exp_gate));
        check({tag, "_alarm"}, 32'(alarm_n), 32'(exp_alarm));
        check({tag, "_bad"},   32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        car1           = '0;
        car2           = '0;
        car3           = '0;
        tag_if.tag_ack = 1'b0;
        tag_if.tag_ok  = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_served1", 32'(served1), 32'd0);
        check("rst_served2", 32'(served2), 32'd0);
        check("rst_served3", 32'(served3), 32'd0);
        check("rst_gate",    32'(gate_open), 32'd0);
        check("rst_req",     32'(tag_if.tag_req), 32'd0);
        check("rst_lane",    32'(tag_if.tag_lane), 32'd0);
        check("rst_alarm",   32'(alarm), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single car on lane 2, ack after 3 cycles
        car2 = 2'd1;
        tick();
        check("t1_latency_req",  32'(tag_if.tag_req), 32'd1);
        check("t1_latency_lane", 32'(tag_if.tag_lane), 32'd1);
        run_txn("t1", 1, 3, 1'b1, 4, 8, 0);
        check("t1_served2", 32'(served2), 32'd1);

        // Three simultaneous arrivals from reset: lane1, lane2, lane3
        do_reset();
        car1 = 2'd1;
        car2 = 2'd1;
        car3 = 2'd1;
        run_txn("t2a", 0, 0, 1'b1, 1, 8, 0);
        run_txn("t2b", 1, 0, 1'b1, 1, 8, 0);
        run_txn("t2c", 2, 0, 1'b1, 1, 8, 0);
        check("t2_served1", 32'(served1), 32'd1);
        check("t2_served2", 32'(served2), 32'd1);
        check("t2_served3", 32'(served3), 32'd1);
        car1 = 2'd2;
        run_txn("t2d", 0, 0, 1'b1, 1, 8, 0);
        check("t2d_served1", 32'(served1), 32'd2);

        // Invalid tag on lane 3: alarm, no gate, car retired
        car3 = 2'd2;
        run_txn("t3", 2, 1, 1'b0, 2, 0, 1);
        check("t3_served3", 32'(served3), 32'd2);

        // Reader timeout on lane 2: 16 req cycles, alarm, car retired
        car2 = 2'd2;
        run_txn("t4", 1, -1, 1'b1, 16, 0, 1);
        check("t4_served2", 32'(served2), 32'd2);

        // Three queued cars on lane 1, then a 3->0 wrap
        do_reset();
        car1 = 2'd1;
        tick();
        car1 = 2'd2;
        tick();
        car1 = 2'd3;
        run_txn("t5a", 0, 0, 1'b1, 1, 8, 0);
        check("t5a_served1", 32'(served1), 32'd1);
        run_txn("t5b", 0, 0, 1'b1, 1, 8, 0);
        check("t5b_served1", 32'(served1), 32'd2);
        run_txn("t5c", 0, 0, 1'b1, 1, 8, 0);
        check("t5c_served1", 32'(served1), 32'd3);
        repeat (3) tick();
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_req",  32'(tag_if.tag_req), 32'd0);
        car1 = 2'd0;
        run_txn("t5d", 0, 0, 1'b1, 1, 8, 0);
        check("t5d_served1", 32'(served1), 32'd0);

        // Reset during OPEN closes the gate at once and clears the counts
        car3 = 2'd1;
        run_txn("t6a", 2, 0, 1'b1, 1, 8, 0);
        check("t6a_served3", 32'(served3), 32'd1);
        car2 = 2'd1;
        car3 = 2'd2;
        wait_req("t6b");
        check("t6b_lane", 32'(tag_if.tag_lane), 32'd1);
        tag_if.tag_ack = 1'b1;
        tag_if.tag_ok  = 1'b1;
        tick();
        tag_if.tag_ack = 1'b0;
        repeat (2) tick();
        check("t6_gate_before", 32'(gate_open), 32'b010);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_gate",    32'(gate_open), 32'd0);
        check("t6_async_served3", 32'(served3), 32'd0);
        check("t6_async_busy",    32'(busy), 32'd0);
        check("t6_async_req",     32'(tag_if.tag_req), 32'd0);
        tick();
        reset_n = 1'b1;
        run_txn("t6c", 1, 0, 1'b1, 1, 8, 0);
        check("t6c_served2", 32'(served2), 32'd1);
        run_txn("t6d", 2, 0, 1'b1, 1, 8, 0);
        run_txn("t6e", 2, 0, 1'b1, 1, 8, 0);
        check("t6e_served3", 32'(served3), 32'd2);
        repeat (3) tick();
        check("t6_final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_gate_ctrl.md
Name: lane_gate_ctrl

Overview:
- Service side of the three-lane car counter: consumes the per-lane 2-bit arrival counts and tracks a per-lane served count; the difference (mod 4) is the number of cars waiting.
- Round-robin selects a waiting lane, handshakes with the ETC tag reader, opens that lane's barrier for a fixed time, then retires one car.
- Sits between the car counter and the barrier/tag-reader interface of the toll station.

Parameters:
- OPEN_CYCLES, 8, cycles gate_open stays high per car (>=1).
- ACK_TIMEOUT, 16, cycles to wait for tag_ack before declaring a reject (>=1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- car1  in  2  lane-1 arrival count, wrapping, same clock domain
- car2  in  2  lane-2 arrival count
- car3  in  2  lane-3 arrival count
- tag_req  out  1  request to tag reader; level, held until ack or timeout
- tag_lane  out  2  lane being read: 0, 1, 2; valid while tag_req=1
- tag_ack  in  1  reader response strobe, sampled only while tag_req=1
- tag_ok  in  1  qualifies tag_ack: 1 = paid, 0 = invalid tag
- gate_open  out  3  one-hot barrier open, bit i = lane i+1
- alarm  out  1  one-cycle pulse on invalid tag or timeout
- served1/served2/served3  out  2 each  per-lane served counts, wrapping
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, reset_n=0): served*=0, gate_open=0, tag_req=0, tag_lane=0, alarm=0, busy=0, rr pointer=lane 1, FSM=IDLE. A reset mid-transaction closes the gates immediately and discards the transaction; the car is not retired.
- pending_i = (car_i - served_i) mod 4, computed combinationally. Lane i waits when pending_i != 0. At most 3 outstanding cars per lane. A 4th outstanding car aliases to 0 and is not detectable; the upstream throughput budget guarantees it does not occur.
- Arbiter: round-robin. The search starts at the lane after the last granted lane (lane 1 after reset). Simultaneous waiters are granted in that rotating order.
- FSM states: IDLE, REQ, OPEN, DONE.
- IDLE: if any lane waits, latch the grant into tag_lane and go to REQ on the next edge. tag_req goes high in the cycle after the lane first shows pending, which gives 1-cycle latency.
- REQ: tag_req=1, timer counts from 0.
  - tag_ack=1 and tag_ok=1: go to OPEN.
  - tag_ack=1 and tag_ok=0: pulse alarm, go to DONE, no gate.
  - timer reaches ACK_TIMEOUT-1 with no ack: pulse alarm, go to DONE.
  - An ack on the timeout cycle wins over the timeout.
  - tag_ack is ignored outside REQ.
- OPEN: gate_open[tag_lane]=1 for exactly OPEN_CYCLES cycles, then go to DONE. tag_req=0.
- DONE: one cycle. served[tag_lane] increments by 1 (mod 4), the rr pointer advances past tag_lane, then go to IDLE. A rejected or timed-out car is also retired.
- Counter edges: car_i may increment in any cycle, including DONE. The new pending value is seen the following cycle. No arrival is ever lost.
- busy=1 in REQ, OPEN, DONE.
- Throughput: one car per (2 + ack latency + OPEN_CYCLES) cycles.
- gate_open is never multi-hot. alarm and gate_open are never high together.

Decomposition:
- Shared package etc_pkg holds:
  - FSM state encoding: IDLE=2'b00, REQ=2'b01, OPEN=2'b10, DONE=2'b11.
  - Lane index constants LANE1=0, LANE2=1, LANE3=2.
  - CNT_W=2, the car-count width shared with the counter block.
- One sub-module: rr_arb3, a 3-request round-robin arbiter.
  - Inputs: req[2:0], last grant.
  - Outputs: grant index, valid.
  - Purely combinational, reusable by other lane logic.

Test Plan:
- Reset then car2 0->1: tag_req=1 with tag_lane=1 the next cycle. Ack with ok=1 after 3 cycles. gate_open=3'b010 for exactly 8 cycles, then served2=1, busy=0.
- car1, car2, car3 all 0->1 in the same cycle, every ack ok: grants in order lane1, lane2, lane3, with served1..3=1 at the end. Then add a car on lane 1 only: it is granted next.
- Invalid tag (ack=1, ok=0) on lane 3: one alarm pulse, gate_open stays 0, served3 increments.
- No ack with ACK_TIMEOUT=16: tag_req is high for exactly 16 cycles, alarm pulses once, the car is retired.
- car1 advances 3 times (pending=3) with ack ok: three back-to-back transactions with served1 going 1,2,3, and pending1=0 afterwards. Then car1 wraps 3->0: the car is served and served1 wraps to 0.
- reset_n dropped during OPEN: gate_open=0 asynchronously and served*=0. After release, the FSM re-requests whichever lane counts are still pending.
